// File: rtl/dual_issue_hazard_ctrl.sv
`default_nettype none
// dual_issue_hazard_ctrl: issue/stall/flush control and W-stage forward selects for a
// two-lane (A older, B younger) in-order pipeline.
module dual_issue_hazard_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidA_D,
  input  logic              ValidB_D,
  input  logic [REG_AW-1:0] Rs1A_D,
  input  logic [REG_AW-1:0] Rs2A_D,
  input  logic [REG_AW-1:0] RdA_D,
  input  logic              RegWriteA_D,
  input  logic [REG_AW-1:0] Rs1B_D,
  input  logic [REG_AW-1:0] Rs2B_D,
  input  logic [REG_AW-1:0] RdB_D,
  input  logic              RegWriteB_D,
  input  logic              TakenA_E,
  input  logic              TakenB_E,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              IssueA_D,
  output logic              IssueB_D,
  output logic              KillB_E,
  output logic [1:0]        ForwardA1E,
  output logic [1:0]        ForwardA2E,
  output logic [1:0]        ForwardB1E,
  output logic [1:0]        ForwardB2E
);

  localparam logic [0:0] ST_PAIR   = 1'b0;
  localparam logic [0:0] ST_B_ONLY = 1'b1;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_WA = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic [REG_AW-1:0] rd;
  } dst_t;

  typedef struct packed {
    dst_t              dst;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ex_t;

  logic [0:0] state_q, state_d;
  ex_t        e_a_q, e_a_d, e_b_q, e_b_d;
  dst_t       m_a_q, m_a_d, m_b_q, m_b_d;
  dst_t       w_a_q, w_b_q;

  logic d_a_vld, d_b_vld;
  logic dep_a, dep_b, intra_dep;
  logic taken_a, taken_b;
  logic stall, flush, issue_a, issue_b, kill_b;

  // Register 0 is hardwired, so it can never be the subject of a hazard.
  function automatic logic hit(input dst_t s, input logic [REG_AW-1:0] r);
    return (r != '0) && s.valid && s.rw && (s.rd == r);
  endfunction

  function automatic logic hit_e(input ex_t ea, input ex_t eb, input logic [REG_AW-1:0] r);
    return hit(ea.dst, r) || hit(eb.dst, r);
  endfunction

  // Lane B is younger, so its W result wins when both lanes wrote the same register.
  function automatic logic [1:0] fwd_sel(input logic lane_vld, input dst_t wa, input dst_t wb,
                                         input logic [REG_AW-1:0] r);
    if (!lane_vld)        return FWD_RF;
    else if (hit(wb, r))  return FWD_WB;
    else if (hit(wa, r))  return FWD_WA;
    else                  return FWD_RF;
  endfunction

  assign d_a_vld = ValidA_D && (state_q == ST_PAIR);
  assign d_b_vld = ValidB_D;

  assign dep_a = d_a_vld && (hit_e(e_a_q, e_b_q, Rs1A_D) || hit_e(e_a_q, e_b_q, Rs2A_D));
  assign dep_b = d_b_vld && (hit_e(e_a_q, e_b_q, Rs1B_D) || hit_e(e_a_q, e_b_q, Rs2B_D));

  assign intra_dep = d_a_vld && d_b_vld && RegWriteA_D && (RdA_D != '0) &&
                     ((RdA_D == Rs1B_D) || (RdA_D == Rs2B_D));

  assign taken_a = TakenA_E && e_a_q.dst.valid;
  assign taken_b = TakenB_E && e_b_q.dst.valid && !taken_a;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    issue_a = 1'b0;
    issue_b = 1'b0;
    kill_b  = 1'b0;
    if (taken_a || taken_b) begin
      // A redirect discards the D pair, so any stall it would have needed is moot.
      flush   = 1'b1;
      kill_b  = taken_a && e_b_q.dst.valid;
      state_d = ST_PAIR;
    end else begin
      case (state_q)
        ST_PAIR: begin
          if (dep_a) begin
            stall = 1'b1;
          end else if (intra_dep || dep_b) begin
            issue_a = d_a_vld;
            stall   = 1'b1;
            state_d = ST_B_ONLY;
          end else begin
            issue_a = d_a_vld;
            issue_b = d_b_vld;
          end
        end
        ST_B_ONLY: begin
          if (dep_b) begin
            stall = 1'b1;
          end else begin
            issue_b = d_b_vld;
            state_d = ST_PAIR;
          end
        end
        default: state_d = ST_PAIR;
      endcase
    end
  end

  always_comb begin
    e_a_d = '0;
    e_b_d = '0;
    if (issue_a) begin
      e_a_d.dst.valid = 1'b1;
      e_a_d.dst.rw    = RegWriteA_D;
      e_a_d.dst.rd    = RdA_D;
      e_a_d.rs1       = Rs1A_D;
      e_a_d.rs2       = Rs2A_D;
    end
    if (issue_b) begin
      e_b_d.dst.valid = 1'b1;
      e_b_d.dst.rw    = RegWriteB_D;
      e_b_d.dst.rd    = RdB_D;
      e_b_d.rs1       = Rs1B_D;
      e_b_d.rs2       = Rs2B_D;
    end
    m_a_d = e_a_q.dst;
    m_b_d = kill_b ? '0 : e_b_q.dst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PAIR;
      e_a_q   <= '0;
      e_b_q   <= '0;
      m_a_q   <= '0;
      m_b_q   <= '0;
      w_a_q   <= '0;
      w_b_q   <= '0;
    end else begin
      state_q <= state_d;
      e_a_q   <= e_a_d;
      e_b_q   <= e_b_d;
      m_a_q   <= m_a_d;
      m_b_q   <= m_b_d;
      w_a_q   <= m_a_q;
      w_b_q   <= m_b_q;
    end
  end

  // D-stage inputs may be live during reset; outputs are forced quiet until it lifts.
  assign StallF   = rst_n && stall;
  assign StallD   = rst_n && stall;
  assign FlushD   = rst_n && flush;
  assign FlushE   = rst_n && flush;
  assign IssueA_D = rst_n && issue_a;
  assign IssueB_D = rst_n && issue_b;
  assign KillB_E  = rst_n && kill_b;

  assign ForwardA1E = rst_n ? fwd_sel(e_a_q.dst.valid, w_a_q, w_b_q, e_a_q.rs1) : FWD_RF;
  assign ForwardA2E = rst_n ? fwd_sel(e_a_q.dst.valid, w_a_q, w_b_q, e_a_q.rs2) : FWD_RF;
  assign ForwardB1E = rst_n ? fwd_sel(e_b_q.dst.valid, w_a_q, w_b_q, e_b_q.rs1) : FWD_RF;
  assign ForwardB2E = rst_n ? fwd_sel(e_b_q.dst.valid, w_a_q, w_b_q, e_b_q.rs2) : FWD_RF;

endmodule
`default_nettype wire
